// File: rtl/piso_pkg.sv
// Shared state type and sizing helpers for the PISO serializer.
// Defining PISO_PARITY_BIT_EN lengthens each frame by one even-parity bit.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  function automatic int piso_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int piso_frame_len(input int width);
`ifdef PISO_PARITY_BIT_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable up-counter with synchronous clear and enable.
// It saturates at LAST, and o_tc flags that terminal count.
module piso_bit_counter #(
  parameter int               CNT_W = 4,
  parameter logic [CNT_W-1:0] LAST  = '1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_value,
  input  logic             i_enable,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_enable && (r_count != LAST)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == LAST);

endmodule

// File: rtl/piso_serializer_tx.sv
// Parallel-in/serial-out transmitter: valid/ready word in, one bit per clock out.
// Optional macro PISO_PARITY_BIT_EN appends an even-parity bit to every frame.
module piso_serializer_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             data_out,
  output logic             out_valid,
  output logic             done,
  output logic             busy
);

  localparam int               FRAME_LEN = piso_frame_len(WIDTH);
  localparam int               CNT_W     = piso_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FRAME_LEN - 1);

  piso_state_t          r_state;
  logic [FRAME_LEN-1:0] r_shift;
  logic [FRAME_LEN-1:0] w_load_word;
  logic                 w_tc;
  logic                 w_last;
  logic                 w_accept;

  // The parity bit sits at whichever end of the register is shifted out last.
  always_comb begin
    w_load_word = '0;
`ifdef PISO_PARITY_BIT_EN
    if (MSB_FIRST) begin
      w_load_word = {data_in, ^data_in};
    end else begin
      w_load_word = {^data_in, data_in};
    end
`else
    w_load_word = data_in;
`endif
  end

  assign w_last     = (r_state == SHIFT) && w_tc;
  assign load_ready = (r_state == IDLE) || w_last;
  assign w_accept   = load_valid && load_ready;

  piso_bit_counter #(
    .CNT_W (CNT_W),
    .LAST  (LAST_CNT)
  ) u_bit_counter (
    .clock        (clock),
    .reset        (reset),
    .i_clear      (w_last && !w_accept),
    .i_load       (w_accept),
    .i_load_value ('0),
    .i_enable     (r_state == SHIFT),
    .o_tc         (w_tc)
  );

  // Clearing the register on the way back to IDLE keeps data_out at 0 there.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_shift <= '0;
    end else if (w_accept) begin
      r_state <= SHIFT;
      r_shift <= w_load_word;
    end else if (r_state == SHIFT) begin
      if (w_tc) begin
        r_state <= IDLE;
        r_shift <= '0;
      end else if (MSB_FIRST) begin
        r_shift <= {r_shift[FRAME_LEN-2:0], 1'b0};
      end else begin
        r_shift <= {1'b0, r_shift[FRAME_LEN-1:1]};
      end
    end
  end

  assign data_out  = MSB_FIRST ? r_shift[FRAME_LEN-1] : r_shift[0];
  assign out_valid = (r_state == SHIFT);
  assign busy      = (r_state == SHIFT);
  assign done      = w_last;

endmodule

// File: tb/tb_piso_serializer_tx.sv
// Scoreboard bench for piso_serializer_tx: an MSB-first and an LSB-first instance
// share one stimulus stream and are checked bit-by-bit against a queue model.
module tb_piso_serializer_tx;

  localparam int WIDTH = 8;
`ifdef PISO_PARITY_BIT_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif

  typedef struct packed {
    logic msbBit;
    logic lsbBit;
    logic last;
  } expBit_t;

  expBit_t sbQ[$];

  logic             clock     = 1'b0;
  logic             reset     = 1'b1;
  logic             loadValid = 1'b0;
  logic [WIDTH-1:0] dataIn    = '0;

  logic readyM, dataM, validM, doneM, busyM;
  logic readyL, dataL, validL, doneL, busyL;

  int assertions = 0;
  int failures   = 0;

  always #5 clock = ~clock;

  piso_serializer_tx #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dutMsb (
    .clock      (clock),
    .reset      (reset),
    .load_valid (loadValid),
    .load_ready (readyM),
    .data_in    (dataIn),
    .data_out   (dataM),
    .out_valid  (validM),
    .done       (doneM),
    .busy       (busyM)
  );

  piso_serializer_tx #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dutLsb (
    .clock      (clock),
    .reset      (reset),
    .load_valid (loadValid),
    .load_ready (readyL),
    .data_in    (dataIn),
    .data_out   (dataL),
    .out_valid  (validL),
    .done       (doneL),
    .busy       (busyL)
  );

  task automatic check1(input string name, input logic act, input logic exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Expected frame: data bits in the requested order, then optional parity.
  task automatic pushWord(input logic [WIDTH-1:0] w);
    expBit_t e;
    for (int i = 0; i < WIDTH; i++) begin
      e.msbBit = w[WIDTH-1-i];
      e.lsbBit = w[i];
      e.last   = (i == FRAME_LEN - 1);
      sbQ.push_back(e);
    end
`ifdef PISO_PARITY_BIT_EN
    e.msbBit = ^w;
    e.lsbBit = ^w;
    e.last   = 1'b1;
    sbQ.push_back(e);
`endif
  endtask

  task automatic checkOutput();
    expBit_t e;
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      check1("msb out_valid", validM, 1'b1);
      check1("msb data_out", dataM, e.msbBit);
      check1("msb done", doneM, e.last);
      check1("msb busy", busyM, 1'b1);
      check1("msb load_ready", readyM, e.last);
      check1("lsb out_valid", validL, 1'b1);
      check1("lsb data_out", dataL, e.lsbBit);
      check1("lsb done", doneL, e.last);
      check1("lsb busy", busyL, 1'b1);
      check1("lsb load_ready", readyL, e.last);
    end else begin
      check1("msb idle out_valid", validM, 1'b0);
      check1("msb idle data_out", dataM, 1'b0);
      check1("msb idle done", doneM, 1'b0);
      check1("msb idle busy", busyM, 1'b0);
      check1("msb idle load_ready", readyM, 1'b1);
      check1("lsb idle out_valid", validL, 1'b0);
      check1("lsb idle data_out", dataL, 1'b0);
      check1("lsb idle done", doneL, 1'b0);
      check1("lsb idle busy", busyL, 1'b0);
      check1("lsb idle load_ready", readyL, 1'b1);
    end
  endtask

  always @(negedge clock) checkOutput();

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] word, input bit keepValid);
    bit accepted;
    accepted  = 1'b0;
    dataIn    = word;
    loadValid = 1'b1;
    for (int c = 0; c < 200 && !accepted; c++) begin
      @(negedge clock);
      #1;
      accepted = (readyM === 1'b1);
      @(posedge clock);
      if (accepted) pushWord(word);
      #1;
    end
    if (!keepValid) loadValid = 1'b0;
    if (!accepted) begin
      assertions++;
      failures++;
      $display("[TB] FAIL handshake: word %h not accepted within 200 cycles, expected accept", word);
    end
  endtask

  task automatic waitDrain();
    for (int c = 0; c < 300 && sbQ.size() > 0; c++) begin
      @(posedge clock);
      #1;
    end
    assertions++;
    if (sbQ.size() > 0) begin
      failures++;
      $display("[TB] FAIL drain: %0d bits still pending, expected 0", sbQ.size());
    end
    idle(2);
  endtask

  initial begin
    logic [WIDTH-1:0] word;
    bit               keep;

    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    idle(5);

    $display("[TB] single word A5");
    applyStimulus(8'hA5, 1'b0);
    waitDrain();

    $display("[TB] single word 01");
    applyStimulus(8'h01, 1'b0);
    waitDrain();

    $display("[TB] back-to-back F0 0F");
    applyStimulus(8'hF0, 1'b1);
    applyStimulus(8'h0F, 1'b0);
    waitDrain();

    $display("[TB] reset mid-frame");
    applyStimulus(8'hFF, 1'b0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    sbQ.delete();
    idle(2);
    reset = 1'b1;
    idle(1);
    applyStimulus(8'h81, 1'b0);
    waitDrain();

    $display("[TB] random words");
    for (int n = 0; n < 40; n++) begin
      word = WIDTH'($urandom);
      keep = 1'($urandom_range(0, 1));
      applyStimulus(word, keep);
      if (!keep && $urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 4)));
    end
    loadValid = 1'b0;
    waitDrain();
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/piso_serializer_tx.md
Name: piso_serializer_tx

Overview:
- Parallel-in/serial-out transmitter: the sending end of the team's single-bit registered data line, driving the serial stream that flip-flop/shift-register receivers capture.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock, with a frame-valid flag and an end-of-word pulse.
- Sits between a word producer (counter, pattern generator) and a serial capture chain.

Parameters:
- WIDTH, 8, data bits per word; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first.

Ports:
- clock  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset: 0 resets immediately, 1 releases; release is sampled on the clock.
- load_valid  input  1  producer offers data_in.
- load_ready  output  1  transmitter can accept a word this cycle.
- data_in  input  WIDTH  parallel word, sampled on handshake.
- data_out  output  1  serial bit, registered.
- out_valid  output  1  data_out carries a frame bit this cycle.
- done  output  1  one-cycle pulse coinciding with the last bit of a frame.
- busy  output  1  high while in SHIFT.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, shift register=0, bit counter=0; data_out=0, out_valid=0, done=0, busy=0. load_ready goes to 1 once the state is IDLE.
- States: IDLE, SHIFT. No other states.
- Handshake: a word is accepted on a rising edge with load_valid=1 and load_ready=1.
  - load_valid with load_ready=0 has no effect.
  - The producer must hold data_in stable while load_valid is asserted.
- load_ready = (state==IDLE) OR (state==SHIFT AND counter==FRAME_LEN-1).
- IDLE -> SHIFT on accept. From the next cycle:
  - out_valid=1, busy=1.
  - data_out = first bit, per MSB_FIRST.
  - Latency from accept edge to first bit: 1 cycle.
- SHIFT: each clock, advance the shift register by one bit and increment the counter, 0..FRAME_LEN-1. FRAME_LEN = WIDTH, or WIDTH+1 with the optional feature.
- Last bit (counter==FRAME_LEN-1): done=1 for exactly this cycle.
  - With an accept on the same edge: stay in SHIFT, reload, counter=0, first bit of the new word next cycle. No gap; gapless back-to-back streaming is required.
  - Without an accept: go to IDLE. Next cycle out_valid=0, busy=0, data_out=0.
- IDLE outputs: data_out is held at 0, out_valid=0, done=0.
- Reset asserted mid-frame: the frame is aborted immediately, all outputs go to reset values, and the partial word is discarded (not resent).
- Counter width: $clog2(WIDTH+1) bits. It never wraps past FRAME_LEN-1.

Optional Feature:
- Macro: PISO_PARITY_BIT_EN.
- Defined:
  - FRAME_LEN = WIDTH+1.
  - After the data bits, one extra bit is sent: the even-parity bit, XOR-reduction of the accepted word, computed at accept.
  - done and load_ready move to the parity-bit cycle.
- Undefined: FRAME_LEN = WIDTH, with no parity logic or storage.

Decomposition:
- Package piso_pkg holds:
  - state enum type (IDLE, SHIFT);
  - localparam function for the counter width;
  - FRAME_LEN derivation helper.
- One natural sub-module: piso_bit_counter, a loadable up-counter with clear, enable and terminal-count output. It drives done and load_ready.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release, load_valid=0 for 5 cycles -> data_out=0, out_valid=0, load_ready=1, done=0 throughout.
- Single word: WIDTH=8, MSB_FIRST=1, data_in=8'hA5 accepted -> from the next cycle, 8 cycles of data_out=1,0,1,0,0,1,0,1 with out_valid=1. done is high only on the 8th bit; IDLE after.
- LSB order: MSB_FIRST=0, data_in=8'h01 -> serial sequence 1,0,0,0,0,0,0,0.
- Back-to-back: 8'hF0 then 8'h0F, with load_valid held through the last bit -> 16 contiguous out_valid cycles, bits 11110000 00001111. Exactly two done pulses; no idle gap.
- Reset mid-frame: accept 8'hFF, assert reset after the 3rd bit -> out_valid/data_out/busy drop to 0 the same cycle. After release, 8'h81 is sent cleanly: 1,0,0,0,0,0,0,1.
- Parity (PISO_PARITY_BIT_EN defined): data_in=8'h07 -> 9 bits 0,0,0,0,0,1,1,1,1 (parity 1). done is on the 9th bit.
